// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller on the picorv32 native bus.
// Latches rising edges of src into PENDING, masks them with ENABLE and
// drives registered lines into the core irq input.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   irqc_sel   bus select (mem_valid & decode hit), held until irqc_ready
//   addr       mem_addr[3:0], only [3:2] decoded
//   wstrb      byte-lane write enables, 0 means read
//   data_i     write data
//   irqc_ready one-cycle completion pulse
//   data_o     read data, valid while irqc_ready=1, 0 otherwise
//   src        NUM_SRC rising-edge sensitive event lines
//   irq_o      to cpu irq, bits IRQ_BASE +: NUM_SRC used, others 0
//
// Register map (addr[3:2]):
//   0 PENDING  read, write-1-to-clear
//   1 ENABLE   read/write
//   2 STATUS   read-only, PENDING & ENABLE
//   3 FORCE    write-1-to-set PENDING, reads 0
//
// Optional feature: define IRQC_SYNC_EN to pass every src bit through a
// 2-flop synchronizer ahead of the edge detector (for asynchronous sources).

module irq_ctrl #(
   parameter int unsigned NUM_SRC  = 8,
   parameter int unsigned IRQ_BASE = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               irqc_sel,
   input  logic [3:0]         addr,
   input  logic [3:0]         wstrb,
   input  logic [31:0]        data_i,
   output logic               irqc_ready,
   output logic [31:0]        data_o,
   input  logic [NUM_SRC-1:0] src,
   output logic [31:0]        irq_o
);

   localparam int unsigned NS = NUM_SRC;

   logic [NS-1:0] src_s;
   logic [NS-1:0] src_q;
   logic [NS-1:0] rise;

   logic [NS-1:0] pend_q;
   logic [NS-1:0] pend_d;
   logic [NS-1:0] en_q;
   logic [NS-1:0] en_d;
   logic [NS-1:0] irq_q;
   logic [NS-1:0] irq_d;

   logic          ready_q;
   logic          ready_d;
   logic [31:0]   data_q;
   logic [31:0]   data_d;

   logic          access;
   logic          wr;
   logic          rd;
   logic          sel_pend;
   logic          sel_en;
   logic          sel_stat;
   logic          sel_force;
   logic [31:0]   lane_m;
   logic [NS-1:0] wmask;
   logic [NS-1:0] wbits;

   // Address bits [1:0] and data bits above NUM_SRC are don't-care.
   logic unused_bits;
   assign unused_bits = ^{addr[1:0], data_i[31:NS]};

   // ------------------------------------------------------------
   // Source conditioning and edge detect
   // ------------------------------------------------------------
`ifdef IRQC_SYNC_EN
   logic [NS-1:0] sync1_q;
   logic [NS-1:0] sync2_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= src;
         sync2_q <= sync1_q;
      end
   end

   assign src_s = sync2_q;
`else
   assign src_s = src;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src_q <= '0;
      end else begin
         src_q <= src_s;
      end
   end

   // History resets to 0, so a line already high at release counts once.
   assign rise = src_s & ~src_q;

   // ------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------
   // A new access is only accepted when the previous completion pulse
   // is not active, which also forms the single-cycle ready pulse.
   assign access    = irqc_sel & ~ready_q;
   assign wr        = access & (|wstrb);
   assign rd        = access & ~(|wstrb);

   assign sel_pend  = (addr[3:2] == 2'd0);
   assign sel_en    = (addr[3:2] == 2'd1);
   assign sel_stat  = (addr[3:2] == 2'd2);
   assign sel_force = (addr[3:2] == 2'd3);

   assign lane_m = {{8{wstrb[3]}}, {8{wstrb[2]}},
                    {8{wstrb[1]}}, {8{wstrb[0]}}};
   assign wmask  = lane_m[NS-1:0];
   assign wbits  = data_i[NS-1:0] & wmask;

   // ------------------------------------------------------------
   // Register next state
   // ------------------------------------------------------------
   always_comb begin
      pend_d = pend_q;
      en_d   = en_q;
      if (wr) begin
         unique case (1'b1)
            sel_pend:  pend_d = pend_q & ~wbits;
            sel_en:    en_d   = (en_q & ~wmask) | wbits;
            sel_stat:  pend_d = pend_q;
            sel_force: pend_d = pend_q | wbits;
         endcase
      end
      // Applied last so a same-cycle edge beats a W1C.
      pend_d = pend_d | rise;
   end

   always_comb begin
      data_d = '0;
      if (rd) begin
         unique case (1'b1)
            sel_pend:  data_d = 32'(pend_q);
            sel_en:    data_d = 32'(en_q);
            sel_stat:  data_d = 32'(pend_q & en_q);
            sel_force: data_d = '0;
         endcase
      end
   end

   assign ready_d = access;
   assign irq_d   = pend_q & en_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q  <= '0;
         en_q    <= '0;
         irq_q   <= '0;
         ready_q <= 1'b0;
         data_q  <= '0;
      end else begin
         pend_q  <= pend_d;
         en_q    <= en_d;
         irq_q   <= irq_d;
         ready_q <= ready_d;
         data_q  <= data_d;
      end
   end

   // ------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------
   assign irqc_ready = ready_q;
   assign data_o     = data_q;

   always_comb begin
      irq_o = '0;
      irq_o[IRQ_BASE +: NS] = irq_q;
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: table-driven, directed and randomized checks of irq_ctrl
// against a per-source behavioural model.

module tb_irq_ctrl;

   localparam int NS = 8;
   localparam int IB = 3;
`ifdef IRQC_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic          clk;
   logic          reset_n;
   logic          irqc_sel;
   logic [3:0]    addr;
   logic [3:0]    wstrb;
   logic [31:0]   data_i;
   logic          irqc_ready;
   logic [31:0]   data_o;
   logic [NS-1:0] src;
   logic [31:0]   irq_o;

   int errors = 0;
   int checks = 0;

   irq_ctrl #(.NUM_SRC(NS), .IRQ_BASE(IB)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .irqc_sel   (irqc_sel),
      .addr       (addr),
      .wstrb      (wstrb),
      .data_i     (data_i),
      .irqc_ready (irqc_ready),
      .data_o     (data_o),
      .src        (src),
      .irq_o      (irq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state
   bit [NS-1:0] m_pend, m_en, m_prev, m_s1, m_s2;
   bit          m_ready;
   bit [31:0]   m_rd, m_irq;

   task automatic model_reset();
      m_pend = '0; m_en = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
      m_ready = 1'b0; m_rd = '0; m_irq = '0;
   endtask

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Advance one clock: predict from current inputs, then compare at negedge.
   task automatic tick();
      bit [NS-1:0] s, np, ne;
      bit [31:0]   nrd, nirq;
      bit          acc, wr;
`ifdef IRQC_SYNC_EN
      s = m_s2;
`else
      s = src;
`endif
      acc = irqc_sel && !m_ready;
      wr  = acc && (wstrb != 4'd0);
      nrd = '0;
      if (acc && !wr) begin
         case (addr[3:2])
            2'd0: nrd = 32'(m_pend);
            2'd1: nrd = 32'(m_en);
            2'd2: nrd = 32'(m_pend & m_en);
            default: nrd = '0;
         endcase
      end
      for (int i = 0; i < NS; i++) begin
         np[i] = m_pend[i];
         ne[i] = m_en[i];
         if (wr && wstrb[i/8]) begin
            case (addr[3:2])
               2'd0: if (data_i[i]) np[i] = 1'b0;
               2'd1: ne[i] = data_i[i];
               2'd3: if (data_i[i]) np[i] = 1'b1;
               default: ;
            endcase
         end
         if (s[i] && !m_prev[i]) np[i] = 1'b1;
      end
      nirq = 32'(m_pend & m_en) << IB;
      @(posedge clk);
      m_irq = nirq; m_pend = np; m_en = ne; m_prev = s;
      m_s2 = m_s1; m_s1 = src; m_ready = acc; m_rd = nrd;
      @(negedge clk);
      chk("model_ready", irqc_ready, m_ready);
      chk("model_data_o", data_o, m_rd);
      chk("model_irq_o", irq_o, m_irq);
   endtask

   task automatic bus(input logic [3:0] a, input logic [3:0] ws,
                      input logic [31:0] d, output logic [31:0] rd);
      irqc_sel = 1'b1; addr = a; wstrb = ws; data_i = d;
      tick();
      chk("ready_pulse", irqc_ready, 1);
      rd = data_o;
      irqc_sel = 1'b0; wstrb = '0; data_i = '0;
      tick();
      chk("ready_drop", irqc_ready, 0);
      chk("data_drop", data_o, 0);
   endtask

   typedef struct {
      logic [3:0]  addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic [31:0] exp_irq;
   } vec_t;

   vec_t vt[$];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      reset_n = 1'b0; irqc_sel = 1'b0; addr = '0; wstrb = '0;
      data_i = '0; src = '0;
      model_reset();

      vt.push_back('{4'h4, 4'h0, 32'h0,        32'h0,  32'h0});
      vt.push_back('{4'h4, 4'hF, 32'h0000_00A5, 32'h0, 32'h0});
      vt.push_back('{4'h4, 4'h0, 32'h0,        32'hA5, 32'h0});
      vt.push_back('{4'h4, 4'h1, 32'hFFFF_FF00, 32'h0, 32'h0});
      vt.push_back('{4'h4, 4'h0, 32'h0,        32'h00, 32'h0});
      vt.push_back('{4'hC, 4'hF, 32'h80,       32'h0,  32'h0});
      vt.push_back('{4'h4, 4'hF, 32'h80,       32'h0,  32'h400});
      vt.push_back('{4'h0, 4'h0, 32'h0,        32'h80, 32'h400});
      vt.push_back('{4'hC, 4'h0, 32'h0,        32'h0,  32'h400});
      vt.push_back('{4'h8, 4'hF, 32'hFF,       32'h0,  32'h400});
      vt.push_back('{4'h8, 4'h0, 32'h0,        32'h80, 32'h400});
      vt.push_back('{4'h0, 4'h0, 32'h0,        32'h80, 32'h400});
      vt.push_back('{4'hC, 4'hF, 32'h80,       32'h0,  32'h400});
      vt.push_back('{4'h0, 4'h0, 32'h0,        32'h80, 32'h400});
      vt.push_back('{4'h0, 4'hF, 32'h80,       32'h0,  32'h0});
      vt.push_back('{4'h0, 4'h0, 32'h0,        32'h0,  32'h0});
      vt.push_back('{4'h4, 4'hF, 32'hFFFF_FFFF, 32'h0, 32'h0});
      vt.push_back('{4'h4, 4'h0, 32'h0,        32'hFF, 32'h0});
      vt.push_back('{4'h4, 4'h2, 32'h0,        32'h0,  32'h0});
      vt.push_back('{4'h4, 4'h0, 32'h0,        32'hFF, 32'h0});
      vt.push_back('{4'h4, 4'h1, 32'h0,        32'h0,  32'h0});
      vt.push_back('{4'h4, 4'h0, 32'h0,        32'h00, 32'h0});

      repeat (2) @(negedge clk);
      chk("rst_ready", irqc_ready, 0);
      chk("rst_data_o", data_o, 0);
      chk("rst_irq_o", irq_o, 0);
      reset_n = 1'b1;
      tick();

      foreach (vt[k]) begin
         bus(vt[k].addr, vt[k].wstrb, vt[k].wdata, rd);
         if (vt[k].wstrb == 4'd0) chk($sformatf("tbl_rd[%0d]", k), rd, vt[k].exp_rd);
         chk($sformatf("tbl_irq[%0d]", k), irq_o, vt[k].exp_irq);
      end

      // Edge to PENDING to irq_o latency
      bus(4'h4, 4'hF, 32'h01, rd);
      src = 8'h01;
      tick();
      src = 8'h00;
      repeat (LAT - 2) tick();
      chk("lat_irq_early", irq_o, 32'h0);
      tick();
      chk("lat_irq", irq_o, 32'h8);
      bus(4'h0, 4'h0, 32'h0, rd);
      chk("pend_src0", rd, 32'h01);

      src = 8'h02;
      tick();
      src = 8'h00;
      repeat (LAT) tick();
      bus(4'h0, 4'h0, 32'h0, rd);
      chk("pend_src1", rd, 32'h03);
      bus(4'h8, 4'h0, 32'h0, rd);
      chk("status_mask", rd, 32'h01);
      chk("irq_masked", irq_o, 32'h8);
      bus(4'h4, 4'hF, 32'h02, rd);
      chk("irq_en2", irq_o, 32'h10);

      // W1C colliding with a rising edge: set wins
      bus(4'h4, 4'hF, 32'h01, rd);
      chk("irq_en1", irq_o, 32'h8);
      src = 8'h01;
`ifdef IRQC_SYNC_EN
      tick();
      tick();
`endif
      bus(4'h0, 4'hF, 32'h01, rd);
      bus(4'h0, 4'h0, 32'h0, rd);
      chk("w1c_vs_edge", rd, 32'h03);
      chk("w1c_vs_edge_irq", irq_o, 32'h8);
      bus(4'h0, 4'hF, 32'h01, rd);
      chk("w1c_irq_drop", irq_o, 32'h0);
      bus(4'h0, 4'h0, 32'h0, rd);
      chk("w1c_clear", rd, 32'h02);
      repeat (5) tick();
      bus(4'h0, 4'h0, 32'h0, rd);
      chk("level_no_reset", rd, 32'h02);
      src = 8'h00;
      tick();

      // Reset in the middle of a read
      bus(4'h4, 4'hF, 32'h02, rd);
      chk("pre_rst_irq", irq_o, 32'h10);
      irqc_sel = 1'b1; addr = 4'h0; wstrb = 4'h0;
      tick();
      chk("pre_rst_data", data_o, 32'h02);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_ready", irqc_ready, 0);
      chk("rst_mid_data_o", data_o, 0);
      chk("rst_mid_irq_o", irq_o, 0);
      model_reset();
      irqc_sel = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      bus(4'h4, 4'h0, 32'h0, rd);
      chk("rst_en", rd, 32'h0);
      bus(4'h0, 4'h0, 32'h0, rd);
      chk("rst_pend", rd, 32'h0);

      // Source already high at reset release gives exactly one edge
      reset_n = 1'b0;
      src = 8'h01;
      #1;
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) tick();
      bus(4'h0, 4'h0, 32'h0, rd);
      chk("high_at_release", rd, 32'h01);
      bus(4'h0, 4'hF, 32'h01, rd);
      repeat (3) tick();
      bus(4'h0, 4'h0, 32'h0, rd);
      chk("high_single_edge", rd, 32'h00);
      src = 8'h00;
      tick();

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            logic [3:0]  ra;
            logic [3:0]  rs;
            logic [31:0] rdv;
            ra = 4'($urandom_range(0, 15));
            rs = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            bus(ra, rs, $urandom, rdv);
         end else begin
            src = NS'($urandom);
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
